// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame controller (bit timing, deserializer strobes, start/parity/stop checks)
module uart_rx_ctrl #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  sampled_bit,
  input  logic [7:0]            p_data,
  output logic                  dat_samp_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  deser_en,
  output logic [3:0]            bit_count,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  strt_glitch,
  output logic                  busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_nxt;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [3:0] idx, idx_nxt;
  logic par_fail, par_fail_nxt, bit_end, exp_par;
  assign bit_end = edge_cnt == prescale_q - PRESCALE_W'(1);
  assign exp_par = par_typ ? ~^p_data : ^p_data;
  assign busy = state != IDLE;
  assign dat_samp_en = busy;
  // state, bit timing and frame bookkeeping; prescale is captured on every entry into START
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      idx        <= '0;
      par_fail   <= 1'b0;
      prescale_q <= '0;
    end else begin
      state    <= state_nxt;
      edge_cnt <= (state == IDLE || bit_end) ? '0 : edge_cnt + PRESCALE_W'(1);
      idx      <= idx_nxt;
      par_fail <= par_fail_nxt;
      if (state_nxt == START && state != START) prescale_q <= prescale;
    end
  end
  // next-state and bit-end decisions; every strobe is confined to a bit-end cycle
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    par_fail_nxt = par_fail;
    deser_en     = 1'b0;
    bit_count    = 4'd0;
    data_valid   = 1'b0;
    par_err      = 1'b0;
    stp_err      = 1'b0;
    strt_glitch  = 1'b0;
    case (state)
      IDLE: state_nxt = rx_in ? IDLE : START;
      START: if (bit_end) begin
        strt_glitch  = sampled_bit;
        state_nxt    = sampled_bit ? IDLE : DATA;
        idx_nxt      = 4'd1;
        par_fail_nxt = 1'b0;
      end
      DATA: if (bit_end) begin
        deser_en  = 1'b1;
        bit_count = idx;
        idx_nxt   = (idx == 4'd8) ? 4'd0 : idx + 4'd1;
        state_nxt = (idx != 4'd8) ? DATA : par_en ? PARITY : STOP;
      end
      PARITY: if (bit_end) begin
        par_err      = sampled_bit != exp_par;
        par_fail_nxt = sampled_bit != exp_par;
        state_nxt    = STOP;
      end
      STOP: if (bit_end) begin
        stp_err    = !sampled_bit;
        data_valid = sampled_bit && !par_fail;
        state_nxt  = rx_in ? IDLE : START;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
